// File: rtl/mix_round_engine.sv
// mix_round_engine: handshaked LANES x WIDTH mixing engine, ROUNDS rounds per job with optional result chaining.
// Define MIX_FINAL_MUL_EN to add a FINAL cycle applying o[i] = o[i]*(2i+3) + (2i+1) after the last round.
module mix_round_engine #(
  parameter int WIDTH  = 32,
  parameter int LANES  = 8,
  parameter int ROUNDS = 12,
  parameter int SHL    = 16,
  parameter int SHR_A  = 17,
  parameter int SHR_B  = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_chain,
  input  logic [LANES*WIDTH-1:0]       seed,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*WIDTH-1:0]       result,
  output logic                         busy,
  output logic [$clog2(ROUNDS+1)-1:0]  round_cnt
);
  localparam int CW = $clog2(ROUNDS + 1);
  localparam int IW = $clog2(LANES);
  localparam int H = LANES / 2;
  localparam int Q = LANES / 4;
  localparam logic [CW-1:0] LAST = CW'(ROUNDS);
  typedef logic [WIDTH-1:0] lane_t;
  typedef logic [LANES*WIDTH-1:0] vec_t;
`ifdef MIX_FINAL_MUL_EN
  typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif
  state_t state, state_n;
  vec_t st, st_n, last, last_n;
  logic [CW-1:0] cnt, cnt_n;
  // Lane indices wrap by truncating to IW bits, which is mod LANES for a power-of-two lane count.
  function automatic vec_t mix(input vec_t s);
    lane_t o [LANES];
    vec_t r;
    for (int i = 0; i < LANES; i++) o[i] = s[i*WIDTH +: WIDTH];
    for (int i = 0; i < LANES; i++) o[i] = o[i] + lane_t'(i);
    for (int i = 0; i < LANES; i++) o[i] = o[i] + o[IW'(i + LANES - 1)];
    for (int i = 0; i < LANES; i++) o[i] = o[i] + o[IW'(i + 1)] - o[IW'(i + H + 1)];
    for (int i = 0; i < LANES; i++) o[i] = o[i] ^ (o[IW'(i + H - 1)] << SHL);
    for (int i = 0; i < LANES; i++) o[i] = o[i] - (o[IW'(i + Q)] >> SHR_A) + (o[IW'(i + H)] >> SHR_B);
    for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = o[i];
    return r;
  endfunction
`ifdef MIX_FINAL_MUL_EN
  function automatic vec_t fmul(input vec_t s);
    vec_t r;
    for (int i = 0; i < LANES; i++)
      r[i*WIDTH +: WIDTH] = s[i*WIDTH +: WIDTH] * lane_t'(2*i + 3) + lane_t'(2*i + 1);
    return r;
  endfunction
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      st    <= '0;
      cnt   <= '0;
      last  <= '0;
    end else begin
      state <= state_n;
      st    <= st_n;
      cnt   <= cnt_n;
      last  <= last_n;
    end
  always_comb begin
    state_n = state;
    st_n    = st;
    cnt_n   = cnt;
    last_n  = last;
    case (state)
      IDLE: if (in_valid) begin
        st_n    = in_chain ? seed ^ last : seed;
        cnt_n   = '0;
        state_n = RUN;
      end
      RUN: if (cnt == LAST) begin
`ifdef MIX_FINAL_MUL_EN
        state_n = FINAL;
`else
        state_n = DONE;
`endif
      end else begin
        st_n  = mix(st);
        cnt_n = cnt + 1'b1;
      end
`ifdef MIX_FINAL_MUL_EN
      FINAL: begin
        st_n    = fmul(st);
        state_n = DONE;
      end
`endif
      DONE: if (out_ready) begin
        last_n  = st;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
`ifdef MIX_FINAL_MUL_EN
  assign busy = state == RUN || state == FINAL;
`else
  assign busy = state == RUN;
`endif
  assign result    = st;
  assign round_cnt = cnt;
endmodule

// File: tb/tb_mix_round_engine.sv
// tb_mix_round_engine: golden-vector checks on a tiny instance plus model-checked jobs on a default instance.
module tb_mix_round_engine;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic s_in_valid = 0, s_in_ready, s_in_chain = 0, s_out_valid, s_out_ready = 0, s_busy;
  logic [31:0] s_seed = '0, s_result;
  logic [0:0] s_round_cnt;
  logic in_valid = 0, in_ready, in_chain = 0, out_valid, out_ready = 0, busy;
  logic [255:0] seed = '0, result;
  logic [3:0] round_cnt;
  int tests = 0, errors = 0;
  logic [255:0] last_ref = '0;
`ifdef MIX_FINAL_MUL_EN
  localparam logic [31:0] GOLD = 32'h53E1B1D0;
  localparam int LAT = 3, DLAT = 14;
`else
  localparam logic [31:0] GOLD = 32'hEC445645;
  localparam int LAT = 2, DLAT = 13;
`endif
  mix_round_engine #(.WIDTH(8), .LANES(4), .ROUNDS(1), .SHL(4), .SHR_A(5), .SHR_B(3)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_chain(s_in_chain),
    .seed(s_seed), .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result),
    .busy(s_busy), .round_cnt(s_round_cnt));
  mix_round_engine u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_chain(in_chain),
    .seed(seed), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .busy(busy), .round_cnt(round_cnt));
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] ref_mix(input logic [255:0] s);
    logic [31:0] o [8];
    logic [255:0] r;
    for (int i = 0; i < 8; i++) o[i] = s[i*32 +: 32];
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 8; i++) o[i] += 32'(i);
      for (int i = 0; i < 8; i++) o[i] += o[(i + 7) % 8];
      for (int i = 0; i < 8; i++) o[i] = o[i] + o[(i + 1) % 8] - o[(i + 5) % 8];
      for (int i = 0; i < 8; i++) o[i] ^= o[(i + 3) % 8] << 16;
      for (int i = 0; i < 8; i++) o[i] = o[i] - (o[(i + 2) % 8] >> 17) + (o[(i + 4) % 8] >> 12);
    end
`ifdef MIX_FINAL_MUL_EN
    for (int i = 0; i < 8; i++) o[i] = o[i] * 32'(2*i + 3) + 32'(2*i + 1);
`endif
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = o[i];
    return r;
  endfunction
  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction
  // Seed, chain and out_ready are scrambled while the job runs; none of it may disturb the result.
  task automatic run_job(input logic [255:0] sd, input logic ch);
    logic [255:0] exp;
    int n;
    exp = ref_mix(ch ? sd ^ last_ref : sd);
    seed = sd;
    in_chain = ch;
    in_valid = 1;
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 40) begin
      check("round_cnt", round_cnt, (n < 12) ? n : 12);
      check("busy_run", {busy, in_ready}, 2'b10);
      seed = rand_vec();
      in_chain = 1'($urandom_range(1, 0));
      out_ready = 1'($urandom_range(1, 0));
      @(negedge clk);
      n++;
    end
    in_valid = 0;
    out_ready = 0;
    check("latency", n, DLAT);
    check("result", result, exp);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("idle_after", {in_ready, out_valid, busy}, 3'b100);
    last_ref = exp;
  endtask
  initial begin
    int n;
    logic [31:0] held;
    repeat (2) @(negedge clk);
    check("rst_s_flags", {s_in_ready, s_out_valid, s_busy}, 3'b100);
    check("rst_s_result", s_result, 0);
    check("rst_s_cnt", s_round_cnt, 0);
    check("rst_flags", {in_ready, out_valid, busy}, 3'b100);
    check("rst_result", result, 0);
    check("rst_cnt", round_cnt, 0);
    rst = 0;
    s_seed = '0;
    s_in_chain = 0;
    s_in_valid = 1;
    @(negedge clk);
    s_in_valid = 0;
    check("s_busy", {s_busy, s_in_ready}, 2'b10);
    n = 0;
    while (!s_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("s_latency", n, LAT);
    check("s_gold", s_result, GOLD);
    held = s_result;
    s_in_valid = 1;
    s_seed = 32'h12345678;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("s_hold", s_result, GOLD);
      check("s_done_flags", {s_in_ready, s_out_valid}, 2'b01);
    end
    s_in_valid = 0;
    s_out_ready = 1;
    @(negedge clk);
    s_out_ready = 0;
    check("s_idle", {s_in_ready, s_out_valid, s_busy}, 3'b100);
    s_seed = held;
    s_in_chain = 1;
    s_in_valid = 1;
    @(negedge clk);
    s_in_valid = 0;
    s_in_chain = 0;
    check("s_chain_load", s_result, 0);
    n = 0;
    while (!s_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("s_chain_latency", n, LAT);
    check("s_chain_gold", s_result, GOLD);
    s_out_ready = 1;
    @(negedge clk);
    s_out_ready = 0;
    for (int j = 0; j < 200; j++) run_job(rand_vec(), 1'($urandom_range(1, 0)));
    seed = rand_vec();
    in_chain = 0;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    n = 0;
    while (round_cnt != 5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_cnt", round_cnt, 5);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid_rst_flags", {in_ready, out_valid, busy}, 3'b100);
    check("mid_rst_result", result, 0);
    check("mid_rst_cnt", round_cnt, 0);
    last_ref = '0;
    run_job(rand_vec(), 1);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
